// File: rtl/counters_pkg.sv
// Shared constants and helpers for the counter lab input conditioning.
// Debounce defaults target a 100 MHz board clock; SIM_DEBOUNCE_CYCLES keeps simulations short.
package counters_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  // Direction of an accepted level change, given the newly accepted level.
  function automatic edge_e accept_edge(input logic new_level);
    if (new_level) begin
      return EDGE_RISE;
    end else begin
      return EDGE_FALL;
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchronizer chain, stability counter, clean level and edge pulses.
// A new level is accepted only after it has held for DEBOUNCE_CYCLES consecutive cycles.
module debounce_channel
  import counters_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_async,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   clean_r;
  logic                   clean_nxt_s;
  logic                   rise_r;
  logic                   rise_nxt_s;
  logic                   fall_r;
  logic                   fall_nxt_s;

  // Synchronizer chain; the oldest stage is the only one the debouncer looks at.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw_async};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // Stability count and acceptance decision; the count can never pass CNT_LAST.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    clean_nxt_s = clean_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    if (s_s == clean_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s   = CNT_ZERO;
      clean_nxt_s = s_s;
      case (accept_edge(s_s))
        EDGE_RISE: rise_nxt_s = 1'b1;
        EDGE_FALL: fall_nxt_s = 1'b1;
        default: begin
          rise_nxt_s = 1'b0;
          fall_nxt_s = 1'b0;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debouncer state and registered outputs; reset discards any count in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      clean_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      clean_r <= clean_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign clean = clean_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

  debounce_channel_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .clean (clean_r),
    .rise  (rise_r),
    .fall  (fall_r)
  );

endmodule

// File: rtl/debounce_channel_chk.sv
// Property checker for one debounced channel: pulses agree with the clean level.
module debounce_channel_chk (
  input logic clk,
  input logic rst,
  input logic clean,
  input logic rise,
  input logic fall
);

  a_rise_fall_exclusive: assert property (@(posedge clk) disable iff (rst) !(rise && fall));

  a_rise_matches_level: assert property (@(posedge clk) disable iff (rst) rise |-> clean);

  a_fall_matches_level: assert property (@(posedge clk) disable iff (rst) fall |-> !clean);

  // An acceptance always restarts the stability count, so pulses never repeat back to back.
  a_rise_single_cycle: assert property (@(posedge clk) disable iff (rst) rise |=> !rise);

  a_fall_single_cycle: assert property (@(posedge clk) disable iff (rst) fall |=> !fall);

endmodule

// File: rtl/sw_debounce_pulse.sv
// Debounces the lab slide switches into clean levels plus single-cycle edge pulses.
// Each switch is handled by an independent debounce_channel.
module sw_debounce_pulse
  import counters_pkg::*;
#(
  parameter int N_SW            = 3,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            CLK100MHZ,
  input  logic            RST,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_CLEAN,
  output logic [N_SW-1:0] SW_RISE,
  output logic [N_SW-1:0] SW_FALL
);

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (CLK100MHZ),
      .rst      (RST),
      .sw_async (SW[i]),
      .clean    (SW_CLEAN[i]),
      .rise     (SW_RISE[i]),
      .fall     (SW_FALL[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Self-checking bench for sw_debounce_pulse with a sample-window reference model.
// Directed scenarios plus a randomized run, all compared cycle by cycle against the model.
module tb_sw_debounce_pulse;
  import counters_pkg::*;

  localparam int N    = 3;
  localparam int SYNC = DEFAULT_SYNC_STAGES;
  localparam int DEB  = SIM_DEBOUNCE_CYCLES;
  localparam int HIST = SYNC + DEB;

  logic         CLK100MHZ = 1'b0;
  logic         RST       = 1'b1;
  logic [N-1:0] SW        = 3'b000;
  logic [N-1:0] SW_CLEAN;
  logic [N-1:0] SW_RISE;
  logic [N-1:0] SW_FALL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  sw_debounce_pulse #(
    .N_SW            (N),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .SW        (SW),
    .SW_CLEAN  (SW_CLEAN),
    .SW_RISE   (SW_RISE),
    .SW_FALL   (SW_FALL)
  );

  // Reference: m_hist[0] is the switch value taken at the latest edge (zero while in reset).
  // A channel flips once the value seen SYNC edges late has differed from its clean
  // level on each of the last DEB edges.
  logic [N-1:0] m_hist [0:HIST-1];
  logic [N-1:0] m_clean = 3'b000;
  logic [N-1:0] m_rise  = 3'b000;
  logic [N-1:0] m_fall  = 3'b000;

  function automatic logic [N-1:0] held_vec();
    logic [N-1:0] v;
    v = {N{1'b1}};
    for (int i = 0; i < N; i++) begin
      for (int j = SYNC - 1; j <= SYNC + DEB - 2; j++) begin
        if (m_hist[j][i] == m_clean[i]) v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  always @(posedge CLK100MHZ) begin
    if (RST) begin
      for (int j = 0; j < HIST; j++) m_hist[j] <= 3'b000;
      m_clean <= 3'b000;
      m_rise  <= 3'b000;
      m_fall  <= 3'b000;
    end else begin
      m_rise  <= held_vec() & ~m_clean;
      m_fall  <= held_vec() & m_clean;
      m_clean <= m_clean ^ held_vec();
      m_hist[0] <= SW;
      for (int j = 1; j < HIST; j++) m_hist[j] <= m_hist[j-1];
    end
  end

  task automatic test_reset();
    logic [N-1:0] exp_clean;
    logic [N-1:0] exp_rise;
    SW  = 3'b111;
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_zero: got clean=%b rise=%b fall=%b, want all 0", SW_CLEAN, SW_RISE, SW_FALL);
      end
    end
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100MHZ);
      exp_clean = (k >= 6) ? 3'b111 : 3'b000;
      exp_rise  = (k == 6) ? 3'b111 : 3'b000;
      n_tests++;
      if (SW_CLEAN !== exp_clean || SW_RISE !== exp_rise || SW_FALL !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=%b fall=000",
                 k, SW_CLEAN, SW_RISE, SW_FALL, exp_clean, exp_rise);
      end
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== {m_clean, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL reset_model k=%0d: got %b/%b/%b, want %b/%b/%b", k, SW_CLEAN, SW_RISE, SW_FALL, m_clean, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_fall();
    logic [N-1:0] exp_clean;
    logic [N-1:0] exp_fall;
    SW = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100MHZ);
      exp_clean = (k >= 6) ? 3'b101 : 3'b111;
      exp_fall  = (k == 6) ? 3'b010 : 3'b000;
      n_tests++;
      if (SW_CLEAN !== exp_clean || SW_FALL !== exp_fall || SW_RISE !== 3'b000) begin
        n_fail++;
        $display("FAIL fall k=%0d: got clean=%b rise=%b fall=%b, want clean=%b rise=000 fall=%b",
                 k, SW_CLEAN, SW_RISE, SW_FALL, exp_clean, exp_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] exp_rise;
    for (int b = 0; b < 4; b++) begin
      SW[1] = (b < 2) ? 1'b1 : 1'b0;
      @(negedge CLK100MHZ);
      n_tests++;
      if (SW_RISE !== 3'b000 || SW_FALL !== 3'b000 || SW_CLEAN !== 3'b101) begin
        n_fail++;
        $display("FAIL bounce_settle b=%0d: got clean=%b rise=%b fall=%b, want clean=101 rise=000 fall=000",
                 b, SW_CLEAN, SW_RISE, SW_FALL);
      end
    end
    SW[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100MHZ);
      exp_rise = (k == 6) ? 3'b010 : 3'b000;
      n_tests++;
      if (SW_RISE !== exp_rise || SW_FALL !== 3'b000 || SW_CLEAN[1] !== (k >= 6)) begin
        n_fail++;
        $display("FAIL bounce k=%0d: got clean=%b rise=%b fall=%b, want rise=%b fall=000 clean[1]=%0d",
                 k, SW_CLEAN, SW_RISE, SW_FALL, exp_rise, (k >= 6));
      end
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== {m_clean, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL bounce_model k=%0d: got %b/%b/%b, want %b/%b/%b", k, SW_CLEAN, SW_RISE, SW_FALL, m_clean, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_glitch();
    SW = 3'b000;
    repeat (8) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== {m_clean, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL glitch_settle: got %b/%b/%b, want %b/%b/%b", SW_CLEAN, SW_RISE, SW_FALL, m_clean, m_rise, m_fall);
      end
    end
    for (int k = 0; k < 13; k++) begin
      SW[0] = (k < 3) ? 1'b1 : 1'b0;
      @(negedge CLK100MHZ);
      n_tests++;
      if (SW_CLEAN[0] !== 1'b0 || SW_RISE[0] !== 1'b0 || SW_FALL[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got clean=%b rise=%b fall=%b, want bit0 all 0", k, SW_CLEAN, SW_RISE, SW_FALL);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_rise;
    SW = 3'b100;
    repeat (5) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if (SW_RISE !== 3'b000 || SW_CLEAN !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_pre: got clean=%b rise=%b, want 000/000", SW_CLEAN, SW_RISE);
      end
    end
    RST = 1'b1;
    @(negedge CLK100MHZ);
    n_tests++;
    if ({SW_CLEAN, SW_RISE, SW_FALL} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got clean=%b rise=%b fall=%b, want all 0", SW_CLEAN, SW_RISE, SW_FALL);
    end
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100MHZ);
      exp_rise = (k == 6) ? 3'b100 : 3'b000;
      n_tests++;
      if (SW_RISE !== exp_rise || SW_FALL !== 3'b000 || SW_CLEAN !== ((k >= 6) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got clean=%b rise=%b fall=%b, want rise=%b", k, SW_CLEAN, SW_RISE, SW_FALL, exp_rise);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp_rise;
    SW = 3'b000;
    repeat (8) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== {m_clean, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL simul_settle: got %b/%b/%b, want %b/%b/%b", SW_CLEAN, SW_RISE, SW_FALL, m_clean, m_rise, m_fall);
      end
    end
    SW = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100MHZ);
      exp_rise = (k == 6) ? 3'b101 : 3'b000;
      n_tests++;
      if (SW_RISE !== exp_rise || SW_FALL !== 3'b000 || SW_CLEAN !== ((k >= 6) ? 3'b101 : 3'b000)) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d: got clean=%b rise=%b fall=%b, want rise=%b", k, SW_CLEAN, SW_RISE, SW_FALL, exp_rise);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if ({SW_CLEAN, SW_RISE, SW_FALL} !== {m_clean, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL random c=%0d: got %b/%b/%b, want %b/%b/%b", c, SW_CLEAN, SW_RISE, SW_FALL, m_clean, m_rise, m_fall);
      end
      RST = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
      if (hold == 0) begin
        SW   = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 9);
      end else begin
        hold = hold - 1;
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fall();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce_pulse.md
# sw_debounce_pulse

- Conditions the raw slide switches of the 8-bit synchronous counter lab, directly upstream of the counter.
- Each asynchronous switch is synchronized into the CLK100MHZ domain, then debounced with a per-channel stability counter.
- Outputs per channel: a clean level, plus single-cycle rising- and falling-edge pulses.
- The counter consumes SW_CLEAN[0] as enable, SW_RISE[1] as its count-advance strobe in place of a switch-driven clock, and SW_CLEAN[2] as its clear.

## Interface
Parameters:
- N_SW, 3: number of switch channels.
- SYNC_STAGES, 2: synchronizer flop depth, ≥2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles a new level must hold before acceptance (10 ms at 100 MHz), ≥2.

Ports:
- CLK100MHZ  in  1  sole clock; all flops rising-edge.
- RST  in  1  synchronous, active-high reset.
- SW  in  N_SW  raw asynchronous switch inputs.
- SW_CLEAN  out  N_SW  debounced switch levels.
- SW_RISE  out  N_SW  one-cycle pulse when SW_CLEAN[i] goes 0→1.
- SW_FALL  out  N_SW  one-cycle pulse when SW_CLEAN[i] goes 1→0.

## Operation
- Channels are fully independent; the rules below apply per bit i.
- Synchronizer: SW[i] passes through a SYNC_STAGES-deep flop chain. The last stage is s.
- Stability counter cnt, width $clog2(DEBOUNCE_CYCLES):
  - s == SW_CLEAN[i]: cnt <= 0.
  - s != SW_CLEAN[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != SW_CLEAN[i] and cnt == DEBOUNCE_CYCLES-1: SW_CLEAN[i] <= s and cnt <= 0. On the same edge, SW_RISE[i] <= s and SW_FALL[i] <= ~s.
- SW_RISE and SW_FALL are deasserted on every other edge. They are registered outputs, never combinational.
- Any return of s to the current clean level before acceptance clears cnt. Glitches shorter than DEBOUNCE_CYCLES are dropped entirely.
- cnt saturates by construction and never wraps.
- SW_RISE[i] and SW_FALL[i] are mutually exclusive.
- Different channels may pulse on the same cycle.

## Timing
- Reset values, on the first edge with RST=1: all synchronizer flops, cnt, SW_CLEAN, SW_RISE and SW_FALL are 0.
- RST dominates any in-flight count. Reset mid-count discards progress, and no pulse is emitted.
- Latency: SW[i] stable from before edge 0 → s valid after SYNC_STAGES edges → SW_CLEAN[i] updates on edge SYNC_STAGES+DEBOUNCE_CYCLES. The pulse is high for exactly the following cycle.
- Switch high at reset release: the channel treats it as a 0→1 transition. It produces SW_RISE[i] SYNC_STAGES+DEBOUNCE_CYCLES edges after RST falls.
- No backpressure; pulses are not held. The consumer must sample every cycle on CLK100MHZ.

## Structure
- Shared package counters_pkg defines:
  - DEFAULT_DEBOUNCE_CYCLES = 1_000_000.
  - SIM_DEBOUNCE_CYCLES = 4.
  - DEFAULT_SYNC_STAGES = 2.
- Sub-module debounce_channel covers the synchronizer, cnt and the per-bit outputs for a single bit.
- The top instantiates it N_SW times in a generate loop.
- The top contains no other logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2, so acceptance takes 6 edges.

- **Reset with switches high:** RST=1 for 2 cycles with SW=3'b111 → all outputs 0 during reset. The 6th edge after release gives SW_CLEAN=111, then SW_RISE=111 for exactly one cycle.
- **Bounce:** SW[1] toggles 0→1→0→1 at 2-cycle intervals, then holds 1 → exactly one SW_RISE[1] pulse, on the 6th edge after the final transition, and no SW_FALL.
- **Glitch rejection:** SW[0] high for 3 cycles, then low → SW_CLEAN[0] stays 0, and SW_RISE[0] and SW_FALL[0] never assert.
- **Fall:** SW[1] changes 1→0 from the settled-high state → SW_CLEAN[1]=0 after 6 edges, with a single-cycle SW_FALL[1] and no SW_RISE[1].
- **Reset mid-count:** SW[2]=1 held 3 cycles past the synchronizer, then RST pulses for 1 cycle while SW[2] stays 1 → no pulse during or after reset until a full 6 edges after release, then a single SW_RISE[2].
- **Simultaneous channels:** SW changes 000→101 on one edge → SW_RISE=101 in a single common cycle, with SW_CLEAN[1] and SW_RISE[1] remaining 0.
